// File: rtl/boot_run_ctrl.sv
// Run-lifecycle sequencer for the single-cycle Datapath: holds the core in reset, streams a
// program into instruction memory, releases reset, then stops the run on halt or timeout.
module boot_run_ctrl #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [31:0] HALT_INSTR = 32'h0000006F,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_last_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_reset_o,
  input  logic [31:0]       core_pc_i,
  input  logic [31:0]       core_instr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   load_count_o,
  output logic [31:0]       cycle_count_o,
  output logic [31:0]       halt_pc_o
);

  // Hold counter runs HOLD_CYC-1 down to 0, so HOLD_CYC must be at least 1.
  localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HoldW-1:0]  HoldInit    = HoldW'(HOLD_CYC - 1);
  localparam logic [ADDR_W-1:0] LastAddr    = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [31:0]       TimeoutLast = 32'(TIMEOUT - 1);
  localparam logic [31:0]       TimeoutVal  = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StLoad, StHold, StRun, StHalted, StTimeout
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic [31:0]       halt_pc_q, halt_pc_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              overflow_q, overflow_d;
  logic              core_reset_q, core_reset_d;
  logic              handshake;

  assign handshake = (state_q == StLoad) && ld_valid_i;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    load_count_d  = load_count_q;
    cycle_count_d = cycle_count_q;
    halt_pc_d     = halt_pc_q;
    hold_d        = hold_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    overflow_d    = overflow_q;

    unique case (state_q)
      StIdle, StHalted, StTimeout: begin
        if (start_i) begin
          state_d       = StLoad;
          addr_d        = '0;
          load_count_d  = '0;
          cycle_count_d = '0;
          halt_pc_d     = '0;
          done_d        = 1'b0;
          timeout_d     = 1'b0;
          overflow_d    = 1'b0;
        end
      end
      StLoad: begin
        if (handshake) begin
          load_count_d = load_count_q + (ADDR_W + 1)'(1);
          if (ld_last_i) begin
            state_d = StHold;
            hold_d  = HoldInit;
          end else if (addr_q == LastAddr) begin
            // Memory full without a last marker: stop loading rather than wrap onto word 0.
            state_d    = StHold;
            hold_d     = HoldInit;
            overflow_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      StHold: begin
        if (hold_q == '0) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      StRun: begin
        if (core_instr_i == HALT_INSTR) begin
          state_d   = StHalted;
          done_d    = 1'b1;
          halt_pc_d = core_pc_i;
        end else if (cycle_count_q == TimeoutLast) begin
          state_d       = StTimeout;
          timeout_d     = 1'b1;
          cycle_count_d = TimeoutVal;
        end else begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered from the next state so the core reset never glitches.
    core_reset_d = (state_d != StRun);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      load_count_q  <= '0;
      cycle_count_q <= '0;
      halt_pc_q     <= '0;
      hold_q        <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
      core_reset_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      load_count_q  <= load_count_d;
      cycle_count_q <= cycle_count_d;
      halt_pc_q     <= halt_pc_d;
      hold_q        <= hold_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      overflow_q    <= overflow_d;
      core_reset_q  <= core_reset_d;
    end
  end

  assign ld_ready_o    = (state_q == StLoad);
  assign imem_we_o     = handshake;
  assign imem_addr_o   = addr_q;
  assign imem_wdata_o  = ld_data_i;
  assign core_reset_o  = core_reset_q;
  assign busy_o        = (state_q == StLoad) || (state_q == StHold) || (state_q == StRun);
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign overflow_o    = overflow_q;
  assign load_count_o  = load_count_q;
  assign cycle_count_o = cycle_count_q;
  assign halt_pc_o     = halt_pc_q;

endmodule

// File: doc/boot_run_ctrl.md
Name: boot_run_ctrl

Overview:
- Sequencer that owns the single-cycle Datapath's run lifecycle: holds the core in reset, streams a program into instruction memory over a valid/ready port, releases reset, then monitors execution.
- Stops the run on a halt instruction (self-loop jal) or on a cycle-budget timeout, and reports status and counts.
- Sits between the host/loader and the Datapath plus its instruction memory, replacing hand-driven reset and memory preload.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in words.
- ADDR_W, 8, word-address width; must equal log2(IMEM_DEPTH).
- TIMEOUT, 1024, maximum RUN cycles before abort.
- HALT_INSTR, 32'h0000006F, encoding treated as halt (jal x0,0).
- HOLD_CYC, 2, cycles core_reset stays high after load, before run.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load/run sequence.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  controller accepts a loader word.
- ld_data  in  32  instruction word.
- ld_last  in  1  marks the final word of the program.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  instruction memory word address.
- imem_wdata  out  32  instruction memory write data.
- core_reset  out  1  active-high reset to the Datapath.
- core_pc  in  32  Datapath PC (status only).
- core_instr  in  32  instruction currently fetched by the Datapath.
- busy  out  1  high in LOAD, HOLD and RUN.
- done  out  1  run ended on halt.
- timeout  out  1  run ended on cycle budget.
- overflow  out  1  load reached IMEM_DEPTH words without ld_last.
- load_count  out  ADDR_W+1  number of words written.
- cycle_count  out  32  number of RUN cycles completed.
- halt_pc  out  32  core_pc captured at halt.

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, HALTED, TIMEOUT.
- Reset (reset=0, async): state IDLE; core_reset=1; ld_ready=0; imem_we=0; busy, done, timeout, overflow=0; all counters and halt_pc=0.
- core_reset is 1 in every state except RUN. It is a registered output with no glitches.
- IDLE: start -> LOAD.
- On any start accepted from IDLE, HALTED or TIMEOUT:
  - Clear done, timeout, overflow, load_count, cycle_count and halt_pc.
  - Set the address counter to 0.
- LOAD: ld_ready=1 (combinational from state).
  - Handshake = ld_valid & ld_ready.
  - imem_we = handshake (combinational, same cycle); imem_addr = address counter; imem_wdata = ld_data.
  - On each handshake, address counter and load_count increment at the edge.
  - Handshake with ld_last=1 -> HOLD.
  - Handshake at address IMEM_DEPTH-1 with ld_last=0 -> HOLD and set overflow=1; no wrap and no overwrite of word 0.
  - ld_valid=0 leaves the controller waiting indefinitely.
  - A single-word program (ld_last on the first word) is legal.
- HOLD: ld_ready=0; core_reset stays 1 for exactly HOLD_CYC cycles, counted by a down-counter, then -> RUN.
- RUN: core_reset=0; cycle_count increments every cycle.
  - Halt check, evaluated each edge in RUN: core_instr == HALT_INSTR -> HALTED, done=1, halt_pc=core_pc. The halt cycle is not counted.
  - Timeout check: otherwise, if cycle_count == TIMEOUT-1 at the edge -> TIMEOUT, timeout=1, cycle_count=TIMEOUT.
  - If halt and timeout occur on the same edge, halt wins.
- HALTED / TIMEOUT: core_reset=1; counters and flags frozen; start -> LOAD.
- start is ignored in LOAD, HOLD and RUN.
- reset asserted mid-LOAD or mid-RUN returns to IDLE immediately. Instruction memory contents are not cleared.
- busy = state ∈ {LOAD, HOLD, RUN}.

Test Plan:
- Reset check: reset=0 -> core_reset=1, ld_ready=0, busy=0, all counters 0. Release reset with no start -> stays IDLE.
- Normal load and halt:
  - Stimulus: start, then 13 words (00500093, 00a00113, 002081b3, …, last 0000006F with ld_last).
  - Required: imem_addr 0..12 with imem_we on each handshake; load_count=13; core_reset low exactly 2 cycles after the final handshake.
  - Required: done=1 and halt_pc=0x30 when the Datapath reaches the jal; timeout=0.
- Backpressure: ld_valid toggled 1/0 on random cycles -> only cycles with ld_valid=1 write; addresses stay contiguous; load_count equals the word count.
- Timeout: TIMEOUT=16, program `addi` then `beq x0,x0,-4` loop -> timeout=1, cycle_count=16, core_reset=1, done=0.
- Overflow: IMEM_DEPTH=8, 10 words with no ld_last -> 8 writes (addresses 0..7), overflow=1, ld_ready=0 after the 8th word, run starts.
- Abort and restart: reset=0 during RUN -> IDLE and core_reset=1 asynchronously. Then start plus reload -> flags clear and the second run completes with done=1.
